// File: rtl/serial_adc_ctrl.sv
// Controller for serial-output SAR ADCs sharing one chip select and conversion clock.
// Generates cs_n and a divided dclock. Drops leading null bits and deserialises each channel MSB-first.
module serial_adc_ctrl #(
  parameter int DATA_W    = 12,
  parameter int LEAD_BITS = 3,
  parameter int NCH       = 1,
  parameter int CLK_DIV   = 1,
  parameter int GAP_CYC   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  cont,
  input  logic [NCH-1:0]        data,
  output logic                  dclock,
  output logic                  cs_n,
  output logic                  busy,
  output logic                  valid,
  output logic [NCH*DATA_W-1:0] dout,
  output logic                  overrun
);

  localparam int HW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam logic [HW-1:0] HMAX = HW'(CLK_DIV - 1);
  localparam logic [GW-1:0] GMAX = GW'(GAP_CYC - 1);

  typedef enum logic [1:0] {IDLE, LEAD, SHIFT, GAP} state_t;

  // With no lead bits to discard, conversion starts directly in SHIFT
  localparam state_t FIRST = (LEAD_BITS == 0) ? SHIFT : LEAD;

  state_t                r_state;
  logic                  r_start;
  logic                  r_cont;
  logic [HW-1:0]         r_hcnt;
  logic [5:0]            r_bcnt;
  logic [GW-1:0]         r_gcnt;
  logic [NCH*DATA_W-1:0] r_shift;
  logic [NCH*DATA_W-1:0] r_dout;
  logic                  r_dclock;
  logic                  r_cs_n;
  logic                  r_busy;
  logic                  r_valid;
  logic                  r_overrun;

  function automatic logic [NCH*DATA_W-1:0] shift_in(
    input logic [NCH*DATA_W-1:0] sr,
    input logic [NCH-1:0]        d
  );
    logic [NCH*DATA_W-1:0] res;
    res = sr;
    for (int i = 0; i < NCH; i++)
      res[i*DATA_W +: DATA_W] = (sr[i*DATA_W +: DATA_W] << 1) | DATA_W'(d[i]);
    return res;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_start   <= 1'b0;
      r_cont    <= 1'b0;
      r_hcnt    <= '0;
      r_bcnt    <= '0;
      r_gcnt    <= '0;
      r_shift   <= '0;
      r_dout    <= '0;
      r_dclock  <= 1'b0;
      r_cs_n    <= 1'b1;
      r_busy    <= 1'b0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      // Requests are registered first; the FSM acts on them one edge later
      r_start   <= start;
      r_cont    <= cont;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
      case (r_state)
        IDLE: begin
          if (r_start || r_cont) begin
            r_state <= FIRST;
            r_cs_n  <= 1'b0;
            r_busy  <= 1'b1;
            r_hcnt  <= '0;
            r_bcnt  <= '0;
          end
        end
        LEAD, SHIFT: begin
          if (r_start) r_overrun <= 1'b1;
          if (r_hcnt != HMAX) begin
            r_hcnt <= r_hcnt + 1'b1;
          end else begin
            r_hcnt   <= '0;
            r_dclock <= ~r_dclock;
            if (!r_dclock) begin
              r_bcnt <= r_bcnt + 1'b1;
              if (r_state == SHIFT) r_shift <= shift_in(r_shift, data);
            end else if (r_state == LEAD) begin
              if (r_bcnt == 6'(LEAD_BITS)) begin
                r_state <= SHIFT;
                r_bcnt  <= '0;
              end
            end else if (r_bcnt == 6'(DATA_W)) begin
              r_cs_n  <= 1'b1;
              r_dout  <= r_shift;
              r_valid <= 1'b1;
              r_gcnt  <= '0;
              r_state <= GAP;
            end
          end
        end
        GAP: begin
          if (r_gcnt != GMAX) begin
            r_gcnt <= r_gcnt + 1'b1;
            if (r_start) r_overrun <= 1'b1;
          end else if (r_cont) begin
            // Re-arm in place; a start landing here is absorbed by this conversion
            r_state <= FIRST;
            r_cs_n  <= 1'b0;
            r_hcnt  <= '0;
            r_bcnt  <= '0;
          end else begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            if (r_start) r_overrun <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign dclock  = r_dclock;
  assign cs_n    = r_cs_n;
  assign busy    = r_busy;
  assign valid   = r_valid;
  assign dout    = r_dout;
  assign overrun = r_overrun;

endmodule
